sb_frame_config_loader: RTL and testbench
=========================================

# sb_frame_config_loader

Configuration writer for frame-based switch-block memories. Accepts a serial configuration bitstream over a valid/ready handshake and drives the `enable`/`address`/`data_in` bus that a switch block's decoder and 2-bit mux memories consume. It walks every memory cell in a fixed order and issues one single-cycle write strobe per bit. It sits between the chip-level bitstream source and one switch-block tile.

## Interface
- `NUM_MEMS`, default 18: number of 2-bit mux memories behind the tile decoder. Range 2..2^(ADDR_WIDTH-1).
- `ADDR_WIDTH`, default 6: total address width.
  - `address[0]` selects the bit within a memory.
  - `address[1:ADDR_WIDTH-1]` is the decoder select.
- `prog_clk` input, 1: configuration clock. This block has one clock.
- `prog_reset_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: single-cycle pulse that begins a load. Ignored unless the block is in IDLE.
- `bit_valid` input, 1: stream bit available.
- `bit_data` input, 1: stream bit value.
- `bit_ready` output, 1: loader accepts `bit_data` this cycle.
- `enable` output [0:0]: decoder enable, i.e. the write strobe.
- `address` output [0:ADDR_WIDTH-1]: cell address.
- `data_in` output [0:0]: write data.
- `busy` output, 1: a load is in progress.
- `done` output, 1: single-cycle pulse when a load completes.
- `error` output, 1: sticky. Cleared on `start`. Only meaningful with the parity feature.

## Operation
- **States:** IDLE, FETCH, SETUP, STROBE, HOLD, and CHECK (CHECK exists only with the parity feature).
- **IDLE:** `busy`=0. On `start`:
  - clear `mem_idx` and `bit_idx`;
  - clear `error`;
  - clear the parity accumulator;
  - go to FETCH.
- **FETCH:** `bit_ready`=1.
  - On `bit_valid`&&`bit_ready`, latch `bit_data` into `data_in`, XOR it into the parity accumulator, and go to SETUP.
  - Without `bit_valid`, stay in FETCH indefinitely.
- **Address:** `address` = {`mem_idx`, `bit_idx`} mapped as `address[0]`=`bit_idx` and `address[1:ADDR_WIDTH-1]`=`mem_idx`. It is registered and stable from SETUP through HOLD.
- **SETUP:** one cycle. `enable`=0, with address and data driven. Go to STROBE.
- **STROBE:** one cycle with `enable`=1. Go to HOLD.
- **HOLD:** one cycle. `enable`=0; address and data are held. Then advance the indices:
  - if `bit_idx`==0, set `bit_idx`=1 and go to FETCH;
  - otherwise set `bit_idx`=0 and increment `mem_idx`;
  - if `mem_idx` was NUM_MEMS-1, go to CHECK when parity is enabled, otherwise to IDLE with a `done` pulse.
- **Write order:** memory 0 bit 0, memory 0 bit 1, memory 1 bit 0, …, memory NUM_MEMS-1 bit 1. This is 2·NUM_MEMS writes in total.
- **Index width:** `mem_idx` is ADDR_WIDTH-1 bits. It never exceeds NUM_MEMS-1, so there is no wrap to an unused decoder output.
- **`start` while busy:** ignored. No restart and no effect on `error`.
- **Reset mid-load:** all outputs and state return to reset values immediately. Any partially written configuration is left as is, and the host must reload.
- **Reset values:** `enable`=0, `address`=0, `data_in`=0, `bit_ready`=0, `busy`=0, `done`=0, `error`=0, state IDLE.
- **`busy`:** 1 in every state except IDLE.

## Timing
- Per bit, from the handshake accept edge: SETUP, STROBE, HOLD, then FETCH. This is 4 cycles per bit at minimum when the stream is always valid.
- A full load takes 8·NUM_MEMS + 1 cycles from `start` to the `done` pulse with back-to-back valid. Add 2 cycles with parity (1 FETCH cycle plus 1 CHECK cycle).
- `enable` is high exactly one cycle per written bit. It is never high in two consecutive cycles.
- `address` and `data_in` change only on the transition into SETUP, which gives one cycle of setup and one cycle of hold around the strobe.
- `bit_ready` is combinational from state only. It never depends on `bit_valid`.
- `done` is asserted in the cycle after the final HOLD (or after CHECK), coincident with the return to IDLE.

## Configuration
- **Macro:** `SB_FRAME_LOADER_PARITY_EN`.
- **Defined:** after the last HOLD, the loader enters FETCH once more and accepts one trailing parity bit, with no write strobe. In CHECK:
  - `error` is set if the accumulator XOR the parity bit ≠ 0 (even parity over data plus parity);
  - `done` pulses on the exit from CHECK.
- **Undefined:**
  - no trailing bit is consumed;
  - the CHECK state and the accumulator are absent;
  - `error` is tied to 0.

## Test plan
- **Reset then full load:** reset, `start`, 36 bits alternating 1,0 with `bit_valid` held high → 36 `enable` pulses; addresses 0,1,2,…,35 (`address[0]`=LSB bit select); `data_in` at each strobe matches the stream; `done` pulses once at cycle 145.
- **Stall:** drop `bit_valid` for 5 cycles after bit 7 → `enable` stays low and `bit_ready` stays high throughout the stall; the load resumes with bit 8 at address {4,0}; total cycle count grows by 5.
- **Reset mid-load:** assert `prog_reset_n`=0 during the STROBE of bit 10 → `enable`=0 and `busy`=0 immediately; after release, `start` restarts at address 0.
- **Start while busy:** pulse `start` during bit 3 → no restart; the address sequence continues unchanged.
- **Parity (macro defined):**
  - 36 bits with eleven 1s, then trailing parity bit 1 → `error`=0 and `done` pulses;
  - repeat with parity bit 0 → `error`=1, which stays set until the next `start`.
- **NUM_MEMS=2, ADDR_WIDTH=2:** 4 writes at addresses 0..3 → `done` pulses after 17 cycles.

Source files
------------

// File: rtl/sb_frame_config_loader.sv
// sb_frame_config_loader
// Serial configuration writer for a frame-based switch-block tile. Bits arrive
// over a valid/ready handshake. Each bit is written into the tile's 2-bit mux
// memories with its own single-cycle strobe. Writes go in the order
// memory 0 bit 0, memory 0 bit 1, memory 1 bit 0, and so on.
//
// Optional feature macro: SB_FRAME_LOADER_PARITY_EN
//   When defined, one trailing even-parity bit is consumed after the last write.
//   That bit is checked in a CHECK state and reported on the sticky 'error' output.
//   When undefined, no trailing bit is taken and 'error' is tied low.

module sb_frame_config_loader #(
    parameter int NUM_MEMS   = 18,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset_n,
    input  logic                  start,
    input  logic                  bit_valid,
    input  logic                  bit_data,
    output logic                  bit_ready,
    output logic [0:0]            enable,
    output logic [0:ADDR_WIDTH-1] address,
    output logic [0:0]            data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int MEM_W = ADDR_WIDTH - 1;
    localparam logic [MEM_W-1:0] LAST_MEM = MEM_W'(NUM_MEMS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
`ifdef SB_FRAME_LOADER_PARITY_EN
        HOLD   = 3'd4,
        CHECK  = 3'd5
`else
        HOLD   = 3'd4
`endif
    } state_t;

    state_t                state_q;
    logic [MEM_W-1:0]      memIdx_q;
    logic                  bitIdx_q;
    logic [0:ADDR_WIDTH-1] addr_q;
    logic                  data_q;
    logic                  enable_q;
    logic                  busy_q;
    logic                  done_q;

`ifdef SB_FRAME_LOADER_PARITY_EN
    logic                  parity_q;
    logic                  trailer_q;
    logic                  error_q;
`endif

    // The handshake ready depends only on the state, never on bit_valid.
    assign bit_ready = (state_q == FETCH);
    assign enable    = enable_q;
    assign address   = addr_q;
    assign data_in   = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef SB_FRAME_LOADER_PARITY_EN
    assign error     = error_q;
`else
    assign error     = 1'b0;
`endif

    // Sequencer: fetch a bit, drive address/data, strobe once, hold, then advance.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q   <= IDLE;
            memIdx_q  <= '0;
            bitIdx_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= 1'b0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SB_FRAME_LOADER_PARITY_EN
            parity_q  <= 1'b0;
            trailer_q <= 1'b0;
            error_q   <= 1'b0;
`endif
        end else begin
            done_q   <= 1'b0;
            enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        memIdx_q  <= '0;
                        bitIdx_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= FETCH;
`ifdef SB_FRAME_LOADER_PARITY_EN
                        parity_q  <= 1'b0;
                        trailer_q <= 1'b0;
                        error_q   <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    if (bit_valid) begin
`ifdef SB_FRAME_LOADER_PARITY_EN
                        parity_q <= parity_q ^ bit_data;
                        if (trailer_q) begin
                            state_q <= CHECK;
                        end else begin
                            data_q                <= bit_data;
                            addr_q[0]             <= bitIdx_q;
                            addr_q[1:ADDR_WIDTH-1] <= memIdx_q;
                            state_q               <= SETUP;
                        end
`else
                        data_q                <= bit_data;
                        addr_q[0]             <= bitIdx_q;
                        addr_q[1:ADDR_WIDTH-1] <= memIdx_q;
                        state_q               <= SETUP;
`endif
                    end
                end
                SETUP: begin
                    enable_q <= 1'b1;
                    state_q  <= STROBE;
                end
                STROBE: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!bitIdx_q) begin
                        bitIdx_q <= 1'b1;
                        state_q  <= FETCH;
                    end else begin
                        bitIdx_q <= 1'b0;
                        if (memIdx_q == LAST_MEM) begin
`ifdef SB_FRAME_LOADER_PARITY_EN
                            trailer_q <= 1'b1;
                            state_q   <= FETCH;
`else
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
`endif
                        end else begin
                            memIdx_q <= memIdx_q + 1'b1;
                            state_q  <= FETCH;
                        end
                    end
                end
`ifdef SB_FRAME_LOADER_PARITY_EN
                CHECK: begin
                    error_q   <= parity_q;
                    trailer_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
                end
`endif
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sb_frame_config_loader.sv
// Testbench for sb_frame_config_loader.
// The bench drives directed bitstreams into two instances: the default 18-memory tile
// and a 2-memory tile. It checks write addresses, write data, strobe spacing, the
// cycle count to done, and reset behaviour. The error flag is checked too, with
// SB_FRAME_LOADER_PARITY_EN either defined or undefined.

module tb_sb_frame_config_loader;

`ifdef SB_FRAME_LOADER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       prog_clk = 1'b0;
    logic       prog_reset_n;
    logic       start, bit_valid, bit_data;
    logic       bit_ready, busy, done, error;
    logic [0:0] enable, data_in;
    logic [0:5] address;

    logic       sStart, sValid, sData;
    logic       sReady, sBusy, sDone, sError;
    logic [0:0] sEnable, sDataIn;
    logic [0:1] sAddress;

    int checks = 0;
    int errors = 0;

    // 100 MHz configuration clock
    always #5 prog_clk = ~prog_clk;

    sb_frame_config_loader #(.NUM_MEMS(18), .ADDR_WIDTH(6)) dut (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
        .enable(enable), .address(address), .data_in(data_in),
        .busy(busy), .done(done), .error(error)
    );

    sb_frame_config_loader #(.NUM_MEMS(2), .ADDR_WIDTH(2)) dutSmall (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(sStart),
        .bit_valid(sValid), .bit_data(sData), .bit_ready(sReady),
        .enable(sEnable), .address(sAddress), .data_in(sDataIn),
        .busy(sBusy), .done(sDone), .error(sError)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Expected cell address for write number n: bit select on address[0], memory on the rest
    function automatic logic [0:5] expAddr(input int n);
        logic [0:5] a;
        a[0]   = n[0];
        a[1:5] = 5'(n >> 1);
        return a;
    endfunction

    // Run one load. Optional parts: a stall before stallBit, a start pulse once
    // startBit bits are consumed, and an async reset during the STROBE of write resetStrobe.
    task automatic applyStimulus(input string name, input logic [35:0] pattern,
                                 input int stallBit, input int stallLen,
                                 input int startBit, input int resetStrobe,
                                 input logic parityBit, input logic expErr);
        int   bitIdx    = 0;
        int   strobes   = 0;
        int   cyc       = 0;
        int   stallLeft = stallLen;
        int   expCycles = 8 * 18 + 1 + stallLen + (PAR ? 2 : 0);
        logic prevEn    = 1'b0;
        bit   startSent = 1'b0;
        bit   finished  = 1'b0;
        logic [0:5] ea;
        @(negedge prog_clk);
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_data  = pattern[0];
        while (!finished && cyc < 2000) begin
            @(negedge prog_clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                checkOutput({name, " busy"}, 32'(busy), 32'd1);
                checkOutput({name, " errClr"}, 32'(error), 32'd0);
            end
            if (enable == 1'b1) begin
                checkOutput({name, " enGap"}, 32'(prevEn), 32'd0);
                ea = expAddr(strobes);
                checkOutput({name, " addr"}, 32'(address), 32'(ea));
                checkOutput({name, " data"}, 32'(data_in), 32'(pattern[strobes]));
                if (strobes == resetStrobe) begin
                    prog_reset_n = 1'b0;
                    #1;
                    checkOutput({name, " rstEn"}, 32'(enable), 32'd0);
                    checkOutput({name, " rstBusy"}, 32'(busy), 32'd0);
                    checkOutput({name, " rstAddr"}, 32'(address), 32'd0);
                    checkOutput({name, " rstReady"}, 32'(bit_ready), 32'd0);
                    @(negedge prog_clk);
                    prog_reset_n = 1'b1;
                    return;
                end
                strobes++;
            end
            prevEn = enable[0];
            if (done) begin
                finished = 1'b1;
            end else begin
                bit_valid = 1'b1;
                if (bit_ready && bitIdx == stallBit && stallLeft > 0) begin
                    checkOutput({name, " stallEn"}, 32'(enable), 32'd0);
                    bit_valid = 1'b0;
                    stallLeft--;
                end
                bit_data = (bitIdx < 36) ? pattern[bitIdx] : parityBit;
                if (bit_ready && bit_valid) bitIdx++;
                if (bitIdx == startBit && !startSent) begin
                    start     = 1'b1;
                    startSent = 1'b1;
                end
            end
        end
        checkOutput({name, " cycles"}, 32'(cyc), 32'(expCycles));
        checkOutput({name, " strobes"}, 32'(strobes), 32'd36);
        checkOutput({name, " error"}, 32'(error), 32'(expErr));
        @(negedge prog_clk);
        checkOutput({name, " donePulse"}, 32'(done), 32'd0);
        checkOutput({name, " idleBusy"}, 32'(busy), 32'd0);
        repeat (3) @(negedge prog_clk);
        checkOutput({name, " errSticky"}, 32'(error), 32'(expErr));
    endtask

    initial begin
        int         cyc;
        int         idx;
        int         strobes;
        logic [3:0] sPat;
        logic [0:1] sa;

        prog_reset_n = 1'b0;
        start = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
        sStart = 1'b0; sValid = 1'b0; sData = 1'b0;
        #1;
        checkOutput("rst enable", 32'(enable), 32'd0);
        checkOutput("rst address", 32'(address), 32'd0);
        checkOutput("rst data_in", 32'(data_in), 32'd0);
        checkOutput("rst ready", 32'(bit_ready), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst error", 32'(error), 32'd0);
        repeat (2) @(negedge prog_clk);
        prog_reset_n = 1'b1;

        applyStimulus("full",   36'h555555555, -1, 0, -1, -1, 1'b0, 1'b0);
        applyStimulus("stall",  36'hA5C30F961,  8, 5, -1, -1, 1'b1, 1'b0);
        applyStimulus("midrst", 36'h555555555, -1, 0, -1, 10, 1'b0, 1'b0);
        applyStimulus("reload", 36'h555555555, -1, 0, -1, -1, 1'b0, 1'b0);
        applyStimulus("busyst", 36'hA5C30F961, -1, 0,  3, -1, 1'b1, 1'b0);
        applyStimulus("parOk",  36'h0000007FF, -1, 0, -1, -1, 1'b1, 1'b0);
        applyStimulus("parBad", 36'h0000007FF, -1, 0, -1, -1, 1'b0, PAR);
        applyStimulus("clear",  36'h555555555, -1, 0, -1, -1, 1'b0, 1'b0);

        // Two-memory tile: four writes at addresses 0..3
        sPat = 4'b1101;
        cyc = 0; idx = 0; strobes = 0;
        @(negedge prog_clk);
        sStart = 1'b1; sValid = 1'b1; sData = sPat[0];
        while (cyc < 200) begin
            @(negedge prog_clk);
            cyc++;
            sStart = 1'b0;
            if (sEnable == 1'b1) begin
                sa[0] = strobes[0];
                sa[1] = strobes[1];
                checkOutput("small addr", 32'(sAddress), 32'(sa));
                checkOutput("small data", 32'(sDataIn), 32'(sPat[strobes]));
                strobes++;
            end
            if (sDone) break;
            sData = (idx < 4) ? sPat[idx] : 1'b1;
            if (sReady && sValid) idx++;
        end
        checkOutput("small cycles", 32'(cyc), 32'(17 + (PAR ? 2 : 0)));
        checkOutput("small strobes", 32'(strobes), 32'd4);
        checkOutput("small error", 32'(sError), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
